register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001: The block SHALL have parameter DATA_WIDTH, default 8, meaning the width of each register and data port.
REQ-002: The block SHALL have parameter NUM_REGS, default 4, meaning the register count; the address width is 2.
REQ-003: The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004: Port clk, input, 1, rising-edge clock.
REQ-005: Port rst_n, input, 1, asynchronous active-low reset.
REQ-006: Port instr_valid, input, 1, instruction and data_in are valid this cycle.
REQ-007: Port instruction, input, 8, opcode [7:4] (opcode_pkg::opcode_t), rd [3:2], rs [1:0].
REQ-008: Port data_in, input, DATA_WIDTH, write-back value from the upstream data-in select.
REQ-009: Port stall, input, 1, freezes the write-back stage and the array.
REQ-010: Port rd_addr_a, input, 2, read port A address.
REQ-011: Port rd_addr_b, input, 2, read port B address.
REQ-012: Port rd_data_a, output, DATA_WIDTH, read port A data.
REQ-013: Port rd_data_b, output, DATA_WIDTH, read port B data.
REQ-014: Port wb_pending, output, 1, the write-back stage holds an uncommitted write.
REQ-015: Port write_count, output, 8, running count of committed writes.

Function
REQ-016: The write-set SHALL be exactly OPCODE_ADD, ADDI, SUB, SUBI, AND, OR, XOR, NOT, LSL, LSR, LDUR, MOV1 and MOV2; all other opcodes SHALL never write.
REQ-017: Capture: on a rising edge with stall=0, instr_valid=1 and the opcode in the write-set, wb_valid SHALL become 1, wb_addr instruction[3:2] and wb_data data_in.
REQ-018: On a rising edge with stall=0 and no capture condition, wb_valid SHALL become 0.
REQ-019: Commit: on a rising edge with stall=0 and wb_valid=1, regs[wb_addr] SHALL be loaded with wb_data.
REQ-020: Write latency SHALL be 2 edges from capture to array update; data SHALL be readable via bypass 1 edge after capture.
REQ-021: A commit of an older write and capture of a newer write on the same edge SHALL both take effect, the older committing and the newer entering the stage.
REQ-022: With stall=1, wb_valid, wb_addr, wb_data, regs and write_count SHALL hold; instruction and instr_valid SHALL be ignored.
REQ-023: Reads SHALL be combinational: rd_data_x = wb_data when wb_valid=1 and wb_addr==rd_addr_x, else regs[rd_addr_x].
REQ-024: Both read ports SHALL be independent and may address the same register.
REQ-025: wb_pending SHALL equal wb_valid.
REQ-026: write_count SHALL increment by 1 on each commit and wrap from 255 to 0.

Reset
REQ-027: rst_n low SHALL immediately clear all regs, wb_valid, wb_addr, wb_data and write_count to 0, independent of clk.
REQ-028: Reset asserted with a write pending SHALL discard that write; no commit occurs.
REQ-029: After rst_n deasserts, the first capture SHALL occur at the first rising edge meeting REQ-017.

Verification
REQ-030: Reset, then read addresses 0..3 on both ports -> all 0x00; wb_pending=0; write_count=0.
REQ-031: ADD with rd=2, data_in=0x5A, rd_addr_a=2 -> edge 1: rd_data_a=0x5A via bypass, wb_pending=1; edge 2: regs[2]=0x5A, wb_pending=0, write_count=1.
REQ-032: Back-to-back MOV1 rd=1 data 0x11, then LDUR rd=1 data 0x22 -> after edge 2 rd_data_a(1)=0x22 via bypass; after edge 3 regs[1]=0x22; write_count=2.
REQ-033: Non-write-set opcode with instr_valid=1, data_in=0xFF -> no capture; regs unchanged; write_count unchanged.
REQ-034: Capture XOR rd=3 data 0x3C, stall=1 for 3 edges, then stall=0 -> wb_pending stays 1 and bypass shows 0x3C throughout; commit on the first unstalled edge.
REQ-035: Capture SUB rd=0 data 0x77, assert rst_n=0 before commit -> regs[0]=0x00, wb_pending=0; 256 commits after reset -> write_count=0.

Source files
------------

// File: rtl/register_file.sv
// Four-entry register file behind a one-deep write-back stage.
// Reads bypass the pending write so a captured value is visible one edge before it commits.
package opcode_pkg;
  typedef enum logic [3:0] {
    OPCODE_ADD  = 4'h0,
    OPCODE_ADDI = 4'h1,
    OPCODE_SUB  = 4'h2,
    OPCODE_SUBI = 4'h3,
    OPCODE_AND  = 4'h4,
    OPCODE_OR   = 4'h5,
    OPCODE_XOR  = 4'h6,
    OPCODE_NOT  = 4'h7,
    OPCODE_LSL  = 4'h8,
    OPCODE_LSR  = 4'h9,
    OPCODE_LDUR = 4'hA,
    OPCODE_STUR = 4'hB,
    OPCODE_CBZ  = 4'hC,
    OPCODE_B    = 4'hD,
    OPCODE_MOV1 = 4'hE,
    OPCODE_MOV2 = 4'hF
  } opcode_t;
endpackage

module register_file
  import opcode_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  input  logic [7:0]            instruction,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  stall,
  input  logic [1:0]            rd_addr_a,
  input  logic [1:0]            rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  wb_pending,
  output logic [7:0]            write_count
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  wb_valid;
  logic [1:0]            wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [7:0]            commit_cnt;

  opcode_t op;
  logic    writes_rd;
  logic    capture;

  assign op = opcode_t'(instruction[7:4]);

  always_comb begin
    writes_rd = 1'b0;
    case (op)
      OPCODE_ADD, OPCODE_ADDI, OPCODE_SUB, OPCODE_SUBI,
      OPCODE_AND, OPCODE_OR, OPCODE_XOR, OPCODE_NOT,
      OPCODE_LSL, OPCODE_LSR, OPCODE_LDUR,
      OPCODE_MOV1, OPCODE_MOV2:                    writes_rd = 1'b1;
      default:                                     writes_rd = 1'b0;
    endcase
  end

  assign capture = instr_valid & writes_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wb_valid   <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      commit_cnt <= '0;
    end else if (!stall) begin
      // The older write commits while a newer one may enter the stage on the same edge.
      if (wb_valid) begin
        regs[wb_addr] <= wb_data;
        commit_cnt    <= commit_cnt + 8'd1;
      end
      wb_valid <= capture;
      if (capture) begin
        wb_addr <= instruction[3:2];
        wb_data <= data_in;
      end
    end
  end

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
    if (wb_valid && (wb_addr == rd_addr_a)) rd_data_a = wb_data;
    if (wb_valid && (wb_addr == rd_addr_b)) rd_data_b = wb_data;
  end

  assign wb_pending  = wb_valid;
  assign write_count = commit_cnt;

endmodule

// File: tb/tb_register_file.sv
// Scoreboarded bench for register_file: directed scenarios plus random traffic
// checked against a queue-of-pending-writes reference model.
module tb_register_file;
  import opcode_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic [7:0] instruction = '0;
  logic [7:0] data_in = '0;
  logic       stall = 1'b0;
  logic [1:0] rd_addr_a = '0;
  logic [1:0] rd_addr_b = '0;
  logic [7:0] rd_data_a, rd_data_b, write_count;
  logic       wb_pending;

  register_file #(.DATA_WIDTH(8), .NUM_REGS(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instruction(instruction),
    .data_in(data_in), .stall(stall), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .wb_pending(wb_pending),
    .write_count(write_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] a; logic [7:0] b; logic p; logic [7:0] c; } exp_t;
  typedef struct { logic [1:0] addr; logic [7:0] data; } wr_t;

  exp_t       sbq[$];
  wr_t        inflight[$];
  logic [7:0] mem [4];
  logic [7:0] mcount;
  int         checks = 0;
  int         errors = 0;

  opcode_t write_set [13] = '{OPCODE_ADD, OPCODE_ADDI, OPCODE_SUB, OPCODE_SUBI, OPCODE_AND,
                              OPCODE_OR, OPCODE_XOR, OPCODE_NOT, OPCODE_LSL, OPCODE_LSR,
                              OPCODE_LDUR, OPCODE_MOV1, OPCODE_MOV2};

  function automatic bit in_write_set(logic [3:0] op);
    foreach (write_set[i]) if (write_set[i] == opcode_t'(op)) return 1'b1;
    return 1'b0;
  endfunction

  // Newest not-yet-committed write to an address wins over the array.
  function automatic logic [7:0] model_read(logic [1:0] addr);
    for (int i = inflight.size() - 1; i >= 0; i--)
      if (inflight[i].addr == addr) return inflight[i].data;
    return mem[addr];
  endfunction

  function automatic void model_clear();
    inflight.delete();
    foreach (mem[i]) mem[i] = 8'h00;
    mcount = 8'h00;
  endfunction

  // Applies the edge that just happened, using the inputs that were present at it.
  function automatic void model_edge();
    wr_t w;
    if (!rst_n || stall) return;
    if (inflight.size() > 0) begin
      w = inflight.pop_front();
      mem[w.addr] = w.data;
      mcount = mcount + 8'd1;
    end
    if (instr_valid && in_write_set(instruction[7:4])) begin
      w.addr = instruction[3:2];
      w.data = data_in;
      inflight.push_back(w);
    end
  endfunction

  function automatic void push_expect();
    exp_t e;
    e.a = model_read(rd_addr_a);
    e.b = model_read(rd_addr_b);
    e.p = (inflight.size() > 0);
    e.c = mcount;
    sbq.push_back(e);
  endfunction

  task automatic drive(input logic v, input logic [3:0] op, input logic [1:0] rd,
                       input logic [7:0] d, input logic st,
                       input logic [1:0] ra, input logic [1:0] rb);
    @(posedge clk);
    #1;
    model_edge();
    rst_n       = 1'b1;
    instr_valid = v;
    instruction = {op, rd, 2'($urandom_range(0, 3))};
    data_in     = d;
    stall       = st;
    rd_addr_a   = ra;
    rd_addr_b   = rb;
    push_expect();
  endtask

  task automatic idle(input logic [1:0] ra, input logic [1:0] rb);
    drive(1'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
          8'($urandom), 1'b0, ra, rb);
  endtask

  // Reset asserted mid-cycle; the monitor sees the cleared state before any clock edge.
  task automatic apply_reset();
    @(posedge clk);
    #1;
    model_edge();
    rst_n = 1'b0;
    model_clear();
    push_expect();
  endtask

  task automatic compare(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%02h required=0x%02h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      compare("rd_data_a", rd_data_a, e.a);
      compare("rd_data_b", rd_data_b, e.b);
      compare("wb_pending", {7'd0, wb_pending}, {7'd0, e.p});
      compare("write_count", write_count, e.c);
    end
  end

  initial begin
    model_clear();
    // Reset state on every address, both ports.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      rd_addr_a = 2'(i);
      rd_addr_b = 2'(3 - i);
      push_expect();
    end
    // ADD rd=2: bypass after one edge, committed after two.
    drive(1'b1, OPCODE_ADD, 2'd2, 8'h5A, 1'b0, 2'd2, 2'd0);
    idle(2'd2, 2'd2);
    idle(2'd2, 2'd1);
    // Back-to-back writes to r1: the newer one shows through the bypass.
    drive(1'b1, OPCODE_MOV1, 2'd1, 8'h11, 1'b0, 2'd1, 2'd2);
    drive(1'b1, OPCODE_LDUR, 2'd1, 8'h22, 1'b0, 2'd1, 2'd1);
    idle(2'd1, 2'd2);
    idle(2'd1, 2'd1);
    // Non-writing opcodes never capture.
    drive(1'b1, OPCODE_STUR, 2'd2, 8'hFF, 1'b0, 2'd2, 2'd0);
    drive(1'b1, OPCODE_CBZ,  2'd1, 8'hFF, 1'b0, 2'd1, 2'd0);
    drive(1'b1, OPCODE_B,    2'd0, 8'hFF, 1'b0, 2'd0, 2'd3);
    idle(2'd2, 2'd1);
    // XOR rd=3 held by a three-edge stall; writes offered during the stall are ignored.
    drive(1'b1, OPCODE_XOR, 2'd3, 8'h3C, 1'b0, 2'd3, 2'd3);
    drive(1'b1, OPCODE_ADD, 2'd0, 8'h99, 1'b1, 2'd3, 2'd0);
    drive(1'b1, OPCODE_ADD, 2'd0, 8'h99, 1'b1, 2'd3, 2'd0);
    drive(1'b1, OPCODE_ADD, 2'd0, 8'h99, 1'b1, 2'd3, 2'd0);
    idle(2'd3, 2'd0);
    idle(2'd3, 2'd0);
    // SUB rd=0 discarded by reset before it commits.
    drive(1'b1, OPCODE_SUB, 2'd0, 8'h77, 1'b0, 2'd0, 2'd3);
    apply_reset();
    idle(2'd0, 2'd3);
    idle(2'd0, 2'd1);
    // 256 commits wrap write_count back to zero.
    for (int i = 0; i < 256; i++)
      drive(1'b1, OPCODE_ADDI, 2'($urandom_range(0, 3)), 8'($urandom), 1'b0,
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    idle(2'd0, 2'd1);
    idle(2'd2, 2'd3);
    // Random traffic with stalls and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) == 0) apply_reset();
      else
        drive(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)),
              2'($urandom_range(0, 3)), 8'($urandom), ($urandom_range(0, 4) == 0),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    idle(2'd0, 2'd1);
    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d entries required=0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
